// File: rtl/adc_sequenciador.sv
// rtl/adc_sequenciador.sv - dual-slope ADC conversion scheduler and watchdog; ADC_HOLD_EN adds the hold port
module adc_sequenciador #(
    parameter int INTERVALO = 4000,
    parameter int TIMEOUT   = 3000,
    parameter int CNT_W     = 16
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        run,
    input  logic        single,
    input  logic        ld,
    input  logic [11:0] bcd_in,
`ifdef ADC_HOLD_EN
    input  logic        hold,
`endif
    output logic        inicio,
    output logic        busy,
    output logic        valid,
    output logic [11:0] result,
    output logic        timeout_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT_LD = 2'd2;
    localparam logic [1:0] S_GAP     = 2'd3;

    localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(INTERVALO - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] timer;
    logic             hold_act;

`ifdef ADC_HOLD_EN
    assign hold_act = hold;
`else
    assign hold_act = 1'b0;
`endif

    // timer is zeroed on the edge that raises inicio, so it reads cycles since t0
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            inicio      <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            result      <= 12'h000;
            timeout_err <= 1'b0;
        end else begin
            inicio <= 1'b0;
            valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run || single) begin
                        state  <= S_START;
                        inicio <= 1'b1;
                        busy   <= 1'b1;
                        timer  <= '0;
                    end
                end
                S_START: begin
                    state <= S_WAIT_LD;
                    timer <= timer + ONE_C;
                end
                S_WAIT_LD: begin
                    timer <= timer + ONE_C;
                    // ld on the watchdog edge still counts as a completed conversion
                    if (ld) begin
                        if (!hold_act) begin
                            result <= bcd_in;
                            valid  <= 1'b1;
                        end
                        timeout_err <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_GAP;
                    end else if (timer >= TMO_C) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (!run) begin
                        state <= S_IDLE;
                    end else if (timer >= LAST_C) begin
                        state  <= S_START;
                        inicio <= 1'b1;
                        busy   <= 1'b1;
                        timer  <= '0;
                    end else begin
                        timer <= timer + ONE_C;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sequenciador.sv
// tb/tb_adc_sequenciador.sv - randomized and directed bench for adc_sequenciador against a cycle-timeline model
module tb_adc_sequenciador;

    localparam int INTERVALO = 20;
    localparam int TIMEOUT   = 12;
    localparam int P_IDLE    = 0;
    localparam int P_CONV    = 1;
    localparam int P_AFTER   = 2;
`ifdef ADC_HOLD_EN
    localparam bit HOLD_PORT = 1'b1;
`else
    localparam bit HOLD_PORT = 1'b0;
`endif

    logic        ck, rst, run, single, ld, hold;
    logic [11:0] bcd_in;
    logic        inicio, busy, valid, timeout_err;
    logic [11:0] result;

    int n_cmp, n_bad, cyc;
    int m_phase, m_t0;
    logic        e_inicio, e_busy, e_valid, e_err;
    logic [11:0] e_result;

    adc_sequenciador #(.INTERVALO(INTERVALO), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .ck(ck),
        .rst(rst),
        .run(run),
        .single(single),
        .ld(ld),
        .bcd_in(bcd_in),
`ifdef ADC_HOLD_EN
        .hold(hold),
`endif
        .inicio(inicio),
        .busy(busy),
        .valid(valid),
        .result(result),
        .timeout_err(timeout_err)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] rand_bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_t0     = 0;
        e_inicio = 1'b0;
        e_busy   = 1'b0;
        e_valid  = 1'b0;
        e_err    = 1'b0;
        e_result = 12'h000;
    endtask

    // Inputs seen during cycle c decide what is visible in cycle c+1; t0 is the inicio cycle
    task automatic model_step(input int c, input logic r, input logic s, input logic l,
                              input logic [11:0] b, input logic h);
        logic frozen;
        frozen   = h && HOLD_PORT;
        e_inicio = 1'b0;
        e_valid  = 1'b0;
        if (m_phase == P_IDLE) begin
            if (r || s) begin
                m_t0 = c + 1; m_phase = P_CONV; e_inicio = 1'b1; e_busy = 1'b1;
            end
        end else if (m_phase == P_CONV) begin
            if (c > m_t0 && l) begin
                if (!frozen) begin
                    e_result = b; e_valid = 1'b1;
                end
                e_err = 1'b0; e_busy = 1'b0; m_phase = P_AFTER;
            end else if (c - m_t0 >= TIMEOUT) begin
                e_err = 1'b1; e_busy = 1'b0; m_phase = P_AFTER;
            end
        end else begin
            if (!r) begin
                m_phase = P_IDLE;
            end else if (c + 1 - m_t0 >= INTERVALO) begin
                m_t0 = c + 1; m_phase = P_CONV; e_inicio = 1'b1; e_busy = 1'b1;
            end
        end
    endtask

    task automatic cyc_step(input logic r, input logic s, input logic l,
                            input logic [11:0] b, input logic h);
        run = r; single = s; ld = l; bcd_in = b; hold = h;
        model_step(cyc, r, s, l, b, h);
        @(posedge ck); #1;
        cyc++;
        check("inicio", inicio, e_inicio);
        check("busy", busy, e_busy);
        check("valid", valid, e_valid);
        check("result", result, e_result);
        check("timeout_err", timeout_err, e_err);
    endtask

    task automatic wait_inicio(input logic r, input string tag, output int at);
        at = -1;
        for (int i = 0; i < 3 * INTERVALO && at < 0; i++) begin
            cyc_step(r, 1'b0, 1'b0, rand_bcd(), 1'b0);
            if (inicio) at = cyc;
        end
        check({tag, "_inicio_seen"}, 32'(at >= 0), 32'd1);
    endtask

    task automatic idle_for(input int n, input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc_step(1'b0, 1'b0, 1'b0, rand_bcd(), 1'b0);
            if (inicio) cnt++;
        end
        check({tag, "_no_inicio"}, 32'(cnt), 32'd0);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_inicio"}, inicio, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_result"}, result, 12'h000);
        check({tag, "_timeout_err"}, timeout_err, 1'b0);
        model_reset();
        run = 1'b0; single = 1'b0; ld = 1'b0;
        @(posedge ck); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        cyc_step(1'b0, 1'b1, 1'b0, rand_bcd(), 1'b0);
        check("single_inicio", inicio, 1'b1);
        repeat (6) cyc_step(1'b0, 1'b0, 1'b0, rand_bcd(), 1'b0);
        cyc_step(1'b0, 1'b0, 1'b1, 12'h357, 1'b0);
        check("single_valid", valid, 1'b1);
        check("single_result", result, 12'h357);
        check("single_busy", busy, 1'b0);
        idle_for(30, "single");
    endtask

    task automatic test_hold();
        int t0, t1;
        wait_inicio(1'b1, "hold", t0);
        repeat (3) cyc_step(1'b1, 1'b0, 1'b0, rand_bcd(), 1'b0);
        cyc_step(1'b1, 1'b0, 1'b1, 12'h999, 1'b1);
        check("hold_valid", valid, 1'b0);
        check("hold_result", result, 12'h357);
        check("hold_busy", busy, 1'b0);
        wait_inicio(1'b1, "hold_next", t1);
        check("hold_period", 32'(t1 - t0), 32'(INTERVALO));
        idle_for(25, "hold");
    endtask

    task automatic test_run_period();
        int last, n;
        logic l;
        last = -1; n = 0;
        for (int i = 0; i < 6 * INTERVALO && n < 6; i++) begin
            l = (last >= 0) && (cyc - last == 5);
            cyc_step(1'b1, 1'b0, l, rand_bcd(), 1'b0);
            if (inicio) begin
                if (last >= 0) check("run_period", 32'(cyc - last), 32'(INTERVALO));
                last = cyc; n++;
            end
        end
        check("run_pulses", 32'(n), 32'd6);
        idle_for(30, "run_stop");
    endtask

    task automatic test_watchdog();
        int t0, t1, t2;
        wait_inicio(1'b1, "limit", t0);
        while (cyc < t0 + TIMEOUT) cyc_step(1'b1, 1'b0, 1'b0, rand_bcd(), 1'b0);
        cyc_step(1'b1, 1'b0, 1'b1, 12'h246, 1'b0);
        check("limit_valid", valid, 1'b1);
        check("limit_err", timeout_err, 1'b0);
        check("limit_result", result, 12'h246);
        wait_inicio(1'b1, "tmo", t1);
        check("tmo_period_a", 32'(t1 - t0), 32'(INTERVALO));
        while (cyc < t1 + TIMEOUT) cyc_step(1'b1, 1'b0, 1'b0, rand_bcd(), 1'b0);
        check("tmo_err_before", timeout_err, 1'b0);
        cyc_step(1'b1, 1'b0, 1'b0, rand_bcd(), 1'b0);
        check("tmo_err_set", timeout_err, 1'b1);
        check("tmo_busy", busy, 1'b0);
        wait_inicio(1'b1, "tmo_next", t2);
        check("tmo_period_b", 32'(t2 - t1), 32'(INTERVALO));
        repeat (3) cyc_step(1'b1, 1'b0, 1'b0, rand_bcd(), 1'b0);
        cyc_step(1'b1, 1'b0, 1'b1, 12'h081, 1'b0);
        check("tmo_clear", timeout_err, 1'b0);
        check("tmo_valid", valid, 1'b1);
        idle_for(25, "tmo");
    endtask

    task automatic test_reset();
        int t0;
        wait_inicio(1'b1, "rst", t0);
        repeat (3) cyc_step(1'b1, 1'b0, 1'b0, rand_bcd(), 1'b0);
        async_reset("rst");
        cyc_step(1'b0, 1'b0, 1'b1, 12'h555, 1'b0);
        check("rst_ld_ignored", valid, 1'b0);
    endtask

    task automatic test_random();
        logic r;
        r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) r = ~r;
            cyc_step(r, $urandom_range(0, 29) == 0, $urandom_range(0, 6) == 0,
                     rand_bcd(), $urandom_range(0, 3) == 0);
            if (i == 700) async_reset("rnd_rst");
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rst = 1'b1; run = 1'b0; single = 1'b0; ld = 1'b0; hold = 1'b0; bcd_in = 12'h000;
        model_reset();
        repeat (2) @(posedge ck);
        #1;
        check("init_inicio", inicio, 1'b0);
        check("init_busy", busy, 1'b0);
        check("init_valid", valid, 1'b0);
        check("init_result", result, 12'h000);
        check("init_timeout_err", timeout_err, 1'b0);
        rst = 1'b0;

        test_single();
`ifdef ADC_HOLD_EN
        test_hold();
`endif
        test_run_period();
        test_watchdog();
        test_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
